// File: rtl/cam_param_if.sv
// cam_param_if: command/result bundle between a CAM client (master) and cam_param (slave).
interface cam_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wen;
    logic              ren;
    logic              inv;
    logic              flush;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] dout;
    logic              hit;
    logic              multi_hit;
    logic [ADDR_W:0]   hit_cnt;
    logic              busy;

    modport master (
        output wen, ren, inv, flush, din, addr,
        input  dout, hit, multi_hit, hit_cnt, busy
    );

    modport slave (
        input  wen, ren, inv, flush, din, addr,
        output dout, hit, multi_hit, hit_cnt, busy
    );
endinterface

// File: rtl/cam_param.sv
// cam_param: DEPTH x DATA_W CAM with registered priority search and flush sweep.
// Define CAM_MATCH_COUNT_EN to build the full match popcount on hit_cnt.
module cam_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    cam_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid, valid_nxt, match;
    logic              do_search, do_write, do_inv;
    logic [ADDR_W-1:0] idx, dout_q;
    logic              any, many, hit_q, multi_q;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        do_search = 1'b0;
        do_write  = 1'b0;
        do_inv    = 1'b0;
        if (state == IDLE) begin
            if (bus.flush) begin
                state_nxt = FLUSH;
                ptr_nxt   = '0;
            end else if (bus.ren) do_search = 1'b1;
            else if (bus.wen) do_write = 1'b1;
            else if (bus.inv) do_inv = 1'b1;
        end else begin
            ptr_nxt = ptr + 1'b1;
            if (&ptr) state_nxt = IDLE;
        end
    end

    always_comb begin
        valid_nxt = valid;
        if (do_write) valid_nxt[bus.addr] = 1'b1;
        if (do_inv) valid_nxt[bus.addr] = 1'b0;
        if (state == FLUSH) valid_nxt[ptr] = 1'b0;
    end

    // Ascending scan so the last match seen is the highest index.
    always_comb begin
        match = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (mem[i] == bus.din);
            if (match[i]) idx = ADDR_W'(i);
        end
    end

    assign any = |match;

`ifdef CAM_MATCH_COUNT_EN
    logic [ADDR_W:0] cnt, cnt_q;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + (ADDR_W+1)'(match[i]);
    end

    assign many = cnt >= (ADDR_W+1)'(2);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= do_search ? cnt : '0;

    assign bus.hit_cnt = cnt_q;
`else
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign many        = |(match & (match - 1'b1));
    assign bus.hit_cnt = '0;
`endif

    always_ff @(posedge clk) if (do_write) mem[bus.addr] <= bus.din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            valid   <= '0;
            dout_q  <= '0;
            hit_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            valid   <= valid_nxt;
            dout_q  <= do_search ? idx : '0;
            hit_q   <= do_search && any;
            multi_q <= do_search && many;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.hit       = hit_q;
    assign bus.multi_hit = multi_q;
    assign bus.busy      = state == FLUSH;
endmodule

// File: tb/tb_cam_param.sv
// tb_cam_param: directed + randomized checks of cam_param against an array-based CAM model.
module tb_cam_param;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [DATA_W-1:0] mem_m [DEPTH];
    bit                val_m [DEPTH];
    int                busy_left = 0;

    cam_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    cam_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input int e_dout, input int e_cnt, input bit e_busy);
        chk("dout", 32'(bus.dout), 32'(e_dout));
        chk("hit", 32'(bus.hit), 32'(e_cnt > 0));
        chk("multi_hit", 32'(bus.multi_hit), 32'(e_cnt >= 2));
`ifdef CAM_MATCH_COUNT_EN
        chk("hit_cnt", 32'(bus.hit_cnt), 32'(e_cnt));
`else
        chk("hit_cnt", 32'(bus.hit_cnt), 32'd0);
`endif
        chk("busy", 32'(bus.busy), 32'(e_busy));
    endtask

    // One clock of commands; the model decides acceptance from flush > ren > wen > inv.
    task automatic step(input bit w, input bit r, input bit iv, input bit f,
                        input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        int e_dout = 0;
        int e_cnt = 0;
        bit idle = busy_left == 0;
        bus.wen = w; bus.ren = r; bus.inv = iv; bus.flush = f; bus.din = d; bus.addr = a;
        if (idle && !f && r)
            for (int k = 0; k < DEPTH; k++)
                if (val_m[k] && mem_m[k] == d) begin
                    e_dout = k;
                    e_cnt++;
                end
        if (idle && !f && !r && w) begin
            mem_m[a] = d;
            val_m[a] = 1'b1;
        end else if (idle && !f && !r && !w && iv) val_m[a] = 1'b0;
        @(posedge clk);
        #1;
        if (idle && f) begin
            for (int k = 0; k < DEPTH; k++) val_m[k] = 1'b0;
            busy_left = DEPTH;
        end else if (busy_left > 0) busy_left--;
        chk_outs(e_dout, e_cnt, busy_left != 0);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, DATA_W'($urandom), ADDR_W'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < DEPTH; k++) val_m[k] = 1'b0;
        busy_left = 0;
        chk_outs(0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] keys [4];
        int busy_cycles;
        keys = '{8'h11, 8'h22, 8'h5A, 8'h00};
        bus.wen = 0; bus.ren = 0; bus.inv = 0; bus.flush = 0; bus.din = '0; bus.addr = '0;
        do_reset();

        step(0, 1, 0, 0, 8'h00, 0);
        chk("plan_empty_hit", 32'(bus.hit), 32'd0);

        step(1, 0, 0, 0, 8'hA5, 3);
        step(1, 0, 0, 0, 8'hA5, 9);
        step(0, 1, 0, 0, 8'hA5, 0);
        chk("plan_two_dout", 32'(bus.dout), 32'd9);
        chk("plan_two_multi", 32'(bus.multi_hit), 32'd1);
        idle_step();

        step(0, 0, 1, 0, 8'h00, 9);
        step(0, 1, 0, 0, 8'hA5, 0);
        chk("plan_inv_dout", 32'(bus.dout), 32'd3);

        step(1, 1, 0, 0, 8'h3C, 5);
        step(0, 1, 0, 0, 8'h3C, 0);
        chk("plan_dropped_write", 32'(bus.hit), 32'd0);

        for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 0, 8'h11, ADDR_W'(k));
        step(0, 1, 0, 0, 8'h11, 0);
        chk("plan_full_cnt_multi", 32'(bus.multi_hit), 32'd1);
        busy_cycles = 0;
        step(0, 0, 0, 1, 8'h11, 0);
        if (bus.busy) busy_cycles++;
        for (int k = 0; k < DEPTH + 4 && bus.busy; k++) begin
            step(k == 2, 0, 0, 0, 8'h11, 7);
            if (bus.busy) busy_cycles++;
        end
        chk("plan_busy_len", 32'(busy_cycles), 32'(DEPTH));
        step(0, 1, 0, 0, 8'h11, 0);
        chk("plan_after_flush", 32'(bus.hit), 32'd0);

        step(1, 0, 0, 0, 8'h44, 2);
        step(0, 0, 0, 1, 8'h00, 0);
        repeat (5) idle_step();
        do_reset();
        chk("plan_reset_busy", 32'(bus.busy), 32'd0);
        step(1, 0, 0, 0, 8'h22, 0);
        step(0, 1, 0, 0, 8'h22, 0);
        chk("plan_reset_hit", 32'(bus.hit), 32'd1);
        chk("plan_reset_dout", 32'(bus.dout), 32'd0);

        for (int n = 0; n < 600; n++) begin
            int p = $urandom_range(0, 99);
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25,
                 p < 2, keys[$urandom_range(0, 3)], ADDR_W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_param.md
# cam_param

Parametrised content-addressable memory: DEPTH entries of DATA_W bits, each with its own valid bit. Supports addressed write, per-entry invalidate, a content search with registered priority-encoded result and multi-hit reporting, and a multi-cycle flush sequencer. It is the general-depth/width successor to the fixed 16x8 CAM and sits in the lookup path of lab designs that need tag matching.

## Interface
- DATA_W, 8, entry/search key width
- ADDR_W, 4, index width; DEPTH = 2**ADDR_W entries
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- wen  input  1  write din into entry addr, set its valid bit
- ren  input  1  search for din among valid entries
- inv  input  1  clear valid bit of entry addr
- flush  input  1  start invalidate-all sweep
- din  input  DATA_W  write data / search key
- addr  input  ADDR_W  target entry for wen/inv
- dout  output  ADDR_W  highest matching index (registered)
- hit  output  1  at least one valid entry matched (registered)
- multi_hit  output  1  two or more valid entries matched (registered)
- hit_cnt  output  ADDR_W+1  number of matching valid entries (registered)
- busy  output  1  flush sweep in progress

## Operation
- Command priority per cycle (one accepted): flush > ren > wen > inv. Lower-priority commands in the same cycle are dropped, not queued.
- Write: mem[addr] <= din, valid[addr] <= 1 on the clock edge.
- Invalidate: valid[addr] <= 0; data left unchanged.
- Search: match[i] = valid[i] && (mem[i] == din). dout = highest i with match[i]; hit = |match; multi_hit = popcount(match) >= 2; hit_cnt = popcount(match).
- Miss: dout = 0, hit = 0, multi_hit = 0, hit_cnt = 0.
- Cycles with no accepted search: dout, hit, multi_hit, hit_cnt register to 0 (results are single-cycle pulses, not held).
- Invalid entries never match, even if stored data equals din.
- FSM states: IDLE, FLUSH.
  - IDLE: flush -> FLUSH, sweep pointer = 0, busy = 1.
  - FLUSH: valid[ptr] <= 0, ptr increments each cycle; after ptr == DEPTH-1 is cleared, -> IDLE, busy = 0. Pointer wraps to 0.
  - In FLUSH all commands (wen, ren, inv, flush) are ignored; search outputs stay 0.
- Reset: all valid bits 0, FSM IDLE, ptr 0, all outputs 0. Memory data is not reset. Reset asserted mid-flush aborts the sweep; all entries are invalid anyway.

## Timing
- Search latency: 1 cycle. Key presented with ren at edge N; results valid after edge N+1, for one cycle.
- Write-then-search: a write at edge N is visible to a search issued in the cycle after edge N. A write and a search in the same cycle: the search wins and the write is dropped.
- Flush: flush sampled at edge N; busy = 1 from edge N through the edge that clears entry DEPTH-1, which is DEPTH cycles later (edge N+DEPTH). busy = 0 after that edge. The first command is accepted at edge N+DEPTH+1.
- busy is a registered output.

## Configuration
- CAM_MATCH_COUNT_EN defined: hit_cnt carries the full popcount and multi_hit is derived from it.
- CAM_MATCH_COUNT_EN undefined: the popcount logic is removed and hit_cnt is tied to 0. multi_hit is still produced by a reduced "two or more matches" detector.
- dout, hit and all other behaviour are identical in both builds.

## Test plan
- Reset, then search din=0x00 -> hit=0, dout=0 (uninitialised/invalid entries never match).
- Write 0xA5 to entries 3 and 9, then search 0xA5 -> one cycle later dout=9, hit=1, multi_hit=1, hit_cnt=2 (hit_cnt=0 if macro off). The following idle cycle: all outputs 0.
- Invalidate entry 9, then search 0xA5 -> dout=3, hit=1, multi_hit=0, hit_cnt=1.
- Assert wen (addr=5, din=0x3C) and ren (din=0x3C) together in one cycle, then search 0x3C -> both searches miss (write dropped).
- Fill all DEPTH entries with 0x11, pulse flush -> busy high for exactly DEPTH cycles; wen pulsed during busy is ignored. Search 0x11 after busy falls -> hit=0.
- Assert rst_n low mid-flush, release, then write and search 0x22 at addr 0 -> busy=0 after reset; search returns dout=0, hit=1.
